// File: rtl/clk_mode_ctrl.sv
// clk_mode_ctrl
//   Sequences a glitch-free mode change on a downstream clock generator.
//   A request runs:
//   1. hold the generator in reset (QUIESCE),
//   2. change its mode select while it is still in reset (SWITCH),
//   3. release reset and wait for the output to settle (SETTLE),
//   4. report lock (LOCKED).
//   Leaving reset runs the same sequence to mode 2'b00.
//
// Parameters
//   RST_CYCLES    cycles div_rst is held before en changes (1..255)
//   SETTLE_CYCLES cycles after div_rst release before locked (1..255)
//   ALLOW_MUL2    1: mode 2'b11 accepted, 0: mode 2'b11 rejected with err
//
// Ports
//   clk_in     in   single clock
//   rst        in   asynchronous active-high reset
//   req_valid  in   mode change request
//   req_mode   in   requested mode (00 div2, 01 div5, 10 div2.5, 11 mul2)
//   req_ready  out  request can be accepted (LOCKED only)
//   en         out  mode select to the clock generator
//   div_rst    out  reset to the clock generator
//   locked     out  downstream clock stable in mode en
//   done       out  one-cycle pulse when a request completes
//   err        out  one-cycle pulse when an illegal request is rejected
//
// All outputs are registered.
module clk_mode_ctrl #(
  parameter int RST_CYCLES    = 2,
  parameter int SETTLE_CYCLES = 10,
  parameter bit ALLOW_MUL2    = 1'b0
) (
  input  logic       clk_in,
  input  logic       rst,
  input  logic       req_valid,
  input  logic [1:0] req_mode,
  output logic       req_ready,
  output logic [1:0] en,
  output logic       div_rst,
  output logic       locked,
  output logic       done,
  output logic       err
);

  typedef enum logic [1:0] {
    QUIESCE = 2'd0,
    SWITCH  = 2'd1,
    SETTLE  = 2'd2,
    LOCKED  = 2'd3
  } state_t;

  localparam logic [7:0] RST_LOAD    = 8'(RST_CYCLES);
  localparam logic [7:0] SETTLE_LOAD = 8'(SETTLE_CYCLES);

  state_t     state, state_nxt;
  logic [7:0] cnt, cnt_nxt;
  logic [1:0] pend, pend_nxt;
  // Set while a user request is in flight, so the sequence that runs
  // after reset ends without a done pulse.
  logic       active, active_nxt;

  logic [1:0] en_nxt;
  logic       div_rst_nxt, locked_nxt, ready_nxt, done_nxt, err_nxt;
  logic       mode_legal;

  assign mode_legal = !((req_mode == 2'b11) && !ALLOW_MUL2);

  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      state     <= QUIESCE;
      cnt       <= RST_LOAD;
      pend      <= 2'b00;
      active    <= 1'b0;
      en        <= 2'b00;
      div_rst   <= 1'b1;
      locked    <= 1'b0;
      req_ready <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      pend      <= pend_nxt;
      active    <= active_nxt;
      en        <= en_nxt;
      div_rst   <= div_rst_nxt;
      locked    <= locked_nxt;
      req_ready <= ready_nxt;
      done      <= done_nxt;
      err       <= err_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    pend_nxt    = pend;
    active_nxt  = active;
    en_nxt      = en;
    div_rst_nxt = div_rst;
    locked_nxt  = locked;
    ready_nxt   = req_ready;
    done_nxt    = 1'b0;
    err_nxt     = 1'b0;

    case (state)
      QUIESCE: begin
        // The counter is loaded on entry, so checking for 1 gives exactly
        // RST_CYCLES cycles here. en moves only while div_rst is still high.
        if (cnt <= 8'd1) begin
          state_nxt = SWITCH;
          en_nxt    = pend;
        end else begin
          cnt_nxt = cnt - 8'd1;
        end
      end

      SWITCH: begin
        state_nxt   = SETTLE;
        cnt_nxt     = SETTLE_LOAD;
        div_rst_nxt = 1'b0;
      end

      SETTLE: begin
        if (cnt <= 8'd1) begin
          state_nxt  = LOCKED;
          locked_nxt = 1'b1;
          ready_nxt  = 1'b1;
          done_nxt   = active;
          active_nxt = 1'b0;
        end else begin
          cnt_nxt = cnt - 8'd1;
        end
      end

      LOCKED: begin
        if (req_valid && req_ready) begin
          if (!mode_legal) begin
            err_nxt = 1'b1;
          end else if (req_mode == en) begin
            done_nxt = 1'b1;
          end else begin
            state_nxt   = QUIESCE;
            cnt_nxt     = RST_LOAD;
            pend_nxt    = req_mode;
            active_nxt  = 1'b1;
            div_rst_nxt = 1'b1;
            locked_nxt  = 1'b0;
            ready_nxt   = 1'b0;
          end
        end
      end

      default: state_nxt = QUIESCE;
    endcase
  end

endmodule

// File: tb/tb_clk_mode_ctrl.sv
// Directed testbench for clk_mode_ctrl. dut0 uses the default parameters
// (mode 2'b11 rejected); dut1 sets ALLOW_MUL2=1 for the mul2 switch.
module tb_clk_mode_ctrl;

  logic       clk_in = 1'b0;
  logic       rst;
  logic       valid0, valid1;
  logic [1:0] mode0, mode1;
  logic       ready0, ready1, div_rst0, div_rst1;
  logic       locked0, locked1, done0, done1, err0, err1;
  logic [1:0] en0, en1;

  int n_chk  = 0;
  int n_fail = 0;
  bit sel    = 1'b0;

  always #5 clk_in = ~clk_in;

  clk_mode_ctrl dut0 (
    .clk_in(clk_in), .rst(rst), .req_valid(valid0), .req_mode(mode0),
    .req_ready(ready0), .en(en0), .div_rst(div_rst0), .locked(locked0),
    .done(done0), .err(err0)
  );

  clk_mode_ctrl #(.ALLOW_MUL2(1'b1)) dut1 (
    .clk_in(clk_in), .rst(rst), .req_valid(valid1), .req_mode(mode1),
    .req_ready(ready1), .en(en1), .div_rst(div_rst1), .locked(locked1),
    .done(done1), .err(err1)
  );

  // Outputs of the instance currently under test.
  logic [1:0] o_en;
  logic       o_div_rst, o_locked, o_ready, o_done, o_err;
  assign o_en      = sel ? en1      : en0;
  assign o_div_rst = sel ? div_rst1 : div_rst0;
  assign o_locked  = sel ? locked1  : locked0;
  assign o_ready   = sel ? ready1   : ready0;
  assign o_done    = sel ? done1    : done0;
  assign o_err     = sel ? err1     : err0;

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge clk_in);
    #1;
  endtask

  task automatic set_req(input logic v, input logic [1:0] m);
    if (sel) begin
      valid1 = v;
      mode1  = m;
    end else begin
      valid0 = v;
      mode0  = m;
    end
  endtask

  // Reset is released just after edge 0; checks edges 1..14.
  task automatic check_reset_release();
    for (int e = 1; e <= 14; e++) begin
      step();
      chk("rel_en", 8'(o_en), 8'h00);
      chk("rel_div_rst", 8'(o_div_rst), 8'(e < 3));
      chk("rel_locked", 8'(o_locked), 8'(e >= 13));
      chk("rel_ready", 8'(o_ready), 8'(e >= 13));
      chk("rel_done", 8'(o_done), 8'h00);
    end
  endtask

  // Accept at edge k (offset 0), observe offsets 0..14. With alt set,
  // req_valid stays high with alternating modes until req_ready returns.
  task automatic run_switch(input logic [1:0] from_m, input logic [1:0] to_m, input bit alt);
    logic [1:0] prev_en;
    prev_en = o_en;
    set_req(1'b1, to_m);
    for (int o = 0; o <= 14; o++) begin
      step();
      if (o_en !== prev_en) chk("en_chg_under_rst", 8'(o_div_rst), 8'h01);
      prev_en = o_en;
      chk("sw_en", 8'(o_en), 8'((o >= 2) ? to_m : from_m));
      chk("sw_div_rst", 8'(o_div_rst), 8'(o < 3));
      chk("sw_locked", 8'(o_locked), 8'(o >= 13));
      chk("sw_ready", 8'(o_ready), 8'(o >= 13));
      chk("sw_done", 8'(o_done), 8'(o == 13));
      chk("sw_err", 8'(o_err), 8'h00);
      if (!alt || o >= 13) set_req(1'b0, 2'b00);
      else set_req(1'b1, o[0] ? 2'b01 : 2'b10);
    end
  endtask

  initial begin
    rst    = 1'b1;
    valid0 = 1'b0; mode0 = 2'b00;
    valid1 = 1'b0; mode1 = 2'b00;

    // Reset state, held over several edges.
    step(); step();
    chk("rst_en", 8'(en0), 8'h00);
    chk("rst_div_rst", 8'(div_rst0), 8'h01);
    chk("rst_locked", 8'(locked0), 8'h00);
    chk("rst_ready", 8'(ready0), 8'h00);
    chk("rst_done", 8'(done0), 8'h00);
    chk("rst_err", 8'(err0), 8'h00);

    rst = 1'b0;
    check_reset_release();

    // 00 -> 01, then 01 -> 10.
    run_switch(2'b00, 2'b01, 1'b0);
    run_switch(2'b01, 2'b10, 1'b0);

    // Same-mode request: done next cycle, nothing else moves.
    set_req(1'b1, 2'b10);
    step();
    set_req(1'b0, 2'b00);
    chk("same_done", 8'(o_done), 8'h01);
    chk("same_err", 8'(o_err), 8'h00);
    chk("same_en", 8'(o_en), 8'h02);
    chk("same_div_rst", 8'(o_div_rst), 8'h00);
    chk("same_locked", 8'(o_locked), 8'h01);
    chk("same_ready", 8'(o_ready), 8'h01);
    step();
    chk("same_done_low", 8'(o_done), 8'h00);
    chk("same_locked2", 8'(o_locked), 8'h01);

    // mul2 rejected on the default instance.
    set_req(1'b1, 2'b11);
    step();
    set_req(1'b0, 2'b00);
    chk("mul2_err", 8'(o_err), 8'h01);
    chk("mul2_done", 8'(o_done), 8'h00);
    chk("mul2_en", 8'(o_en), 8'h02);
    chk("mul2_div_rst", 8'(o_div_rst), 8'h00);
    chk("mul2_locked", 8'(o_locked), 8'h01);
    step();
    chk("mul2_err_low", 8'(o_err), 8'h00);
    chk("mul2_en2", 8'(o_en), 8'h02);

    // Request held with changing modes during a switch: only 00 is taken.
    run_switch(2'b10, 2'b00, 1'b1);
    step();
    chk("alt_en_final", 8'(o_en), 8'h00);
    chk("alt_locked_final", 8'(o_locked), 8'h01);

    // mul2 accepted on the ALLOW_MUL2 instance.
    sel = 1'b1;
    run_switch(2'b00, 2'b11, 1'b0);
    sel = 1'b0;

    // Reset mid-switch at offset 5 of 00 -> 01.
    set_req(1'b1, 2'b01);
    step();
    set_req(1'b0, 2'b00);
    for (int o = 1; o <= 5; o++) step();
    chk("mid_en_before", 8'(o_en), 8'h01);
    chk("mid_div_rst_before", 8'(o_div_rst), 8'h00);
    rst = 1'b1;
    #1;
    chk("mid_en", 8'(o_en), 8'h00);
    chk("mid_div_rst", 8'(o_div_rst), 8'h01);
    chk("mid_locked", 8'(o_locked), 8'h00);
    chk("mid_ready", 8'(o_ready), 8'h00);
    chk("mid_done", 8'(o_done), 8'h00);
    chk("mid_err", 8'(o_err), 8'h00);
    step();
    rst = 1'b0;
    check_reset_release();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  // Absolute guard against a stuck run.
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, got running expected done");
    $fatal(1, "timeout");
  end

endmodule
